divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider_if.sv | 22 ++
 rtl/divider.sv | 136 +++++++++++++
 tb/tb_divider.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// rtl/divider_if.sv - operand/result bundle between divider control and the divider core
interface divider_if #(
    parameter int WIDTH = 32
);
    logic             divOp;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic             div_done;
    logic             div_zero;

    modport master (
        output divOp, dividend, divisor,
        input  div_hi, div_lo, div_done, div_zero
    );

    modport slave (
        input  divOp, dividend, divisor,
        output div_hi, div_lo, div_done, div_zero
    );
endinterface

// File: rtl/divider.sv
// rtl/divider.sv - signed restoring divider with MIPS DIV semantics (one bit per clock)
module divider #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    divider_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH:0]   rem_q,    rem_d;
    logic [WIDTH-1:0] quo_q,    quo_d;
    logic [WIDTH-1:0] dvs_q,    dvs_d;
    logic             sign_n_q, sign_n_d;
    logic             sign_d_q, sign_d_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic             done_q,   done_d;
    logic             zero_q,   zero_d;

    logic [WIDTH-1:0] mag_n;
    logic [WIDTH-1:0] mag_d;
    logic [WIDTH:0]   shifted;

    // Unary minus of the most negative value yields the same bit pattern,
    // which read as unsigned is exactly its magnitude.
    assign mag_n   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign mag_d   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        sign_n_d = sign_n_q;
        sign_d_d = sign_d_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = done_q;
        zero_d   = zero_q;

        if (!bus.divOp) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = '0;
            done_d  = 1'b0;
            zero_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dvs_d    = mag_d;
                    quo_d    = mag_n;
                    rem_d    = '0;
                    cnt_d    = '0;
                    sign_n_d = bus.dividend[WIDTH-1];
                    sign_d_d = bus.divisor[WIDTH-1];
                    if (bus.divisor == '0) begin
                        state_d = S_DONE;
                        zero_d  = 1'b1;
                        done_d  = 1'b1;
                        hi_d    = '0;
                        lo_d    = '0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (shifted >= {1'b0, dvs_q}) begin
                        rem_d = shifted - {1'b0, dvs_q};
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted;
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    lo_d    = (sign_n_q ^ sign_d_q) ? -quo_q : quo_q;
                    hi_d    = sign_n_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sign_n_q <= 1'b0;
            sign_d_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sign_n_q <= sign_n_d;
            sign_d_q <= sign_d_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.div_hi   = hi_q;
    assign bus.div_lo   = lo_q;
    assign bus.div_done = done_q;
    assign bus.div_zero = zero_q;
endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed self-checking bench for the divider
module tb_divider;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    divider_if #(.WIDTH(32)) bus ();

    divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_clear(input string tag);
        check({tag, "_hi"},   bus.div_hi, 32'h0);
        check({tag, "_lo"},   bus.div_lo, 32'h0);
        check({tag, "_done"}, {31'b0, bus.div_done}, 32'h0);
        check({tag, "_zero"}, {31'b0, bus.div_zero}, 32'h0);
    endtask

    // Waits out 33 edges expecting no done, then checks the result on edge 34.
    // Operands are scrambled right after the start edge to prove they are not reused.
    task automatic expect_result(input string tag, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        logic [31:0] early;
        early = 32'h0;
        for (int e = 1; e <= 33; e++) begin
            tick();
            if (e == 1) begin
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
            end
            if (bus.div_done !== 1'b0) early = early + 32'h1;
        end
        check({tag, "_early_done"}, early, 32'h0);
        tick();
        check({tag, "_lo"},   bus.div_lo, exp_lo);
        check({tag, "_hi"},   bus.div_hi, exp_hi);
        check({tag, "_done"}, {31'b0, bus.div_done}, 32'h1);
        check({tag, "_zero"}, {31'b0, bus.div_zero}, 32'h0);
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        bus.dividend = a;
        bus.divisor  = b;
        bus.divOp    = 1'b1;
        expect_result(tag, exp_lo, exp_hi);
        for (int i = 0; i < 3; i++) tick();
        check({tag, "_hold_lo"},   bus.div_lo, exp_lo);
        check({tag, "_hold_hi"},   bus.div_hi, exp_hi);
        check({tag, "_hold_done"}, {31'b0, bus.div_done}, 32'h1);
        bus.divOp = 1'b0;
        tick();
        check_clear({tag, "_clr"});
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.divOp    = 1'b0;
        bus.dividend = 32'h0;
        bus.divisor  = 32'h0;
        #1;
        check_clear("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check_clear("idle_low");

        run_div("p100_7",   32'd100,       32'd7,         32'h0000000E, 32'h00000002);
        run_div("n100_7",   32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2, 32'hFFFFFFFE);
        run_div("p100_n7",  32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2, 32'h00000002);
        run_div("n100_n7",  32'hFFFFFF9C,  32'hFFFFFFF9,  32'h0000000E, 32'hFFFFFFFE);
        run_div("min_neg1", 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 32'h00000000);
        run_div("min_2",    32'h80000000,  32'd2,         32'hC0000000, 32'h00000000);
        run_div("zero_5",   32'd0,         32'd5,         32'h00000000, 32'h00000000);
        run_div("small_3",  32'd3,         32'd10,        32'h00000000, 32'h00000003);
        run_div("small_n3", 32'hFFFFFFFD,  32'd10,        32'h00000000, 32'hFFFFFFFD);
        run_div("max_1",    32'h7FFFFFFF,  32'd1,         32'h7FFFFFFF, 32'h00000000);
        run_div("big",      32'd1000000,   32'd999,       32'd1001,     32'd1);

        // Divide by zero completes on the first edge and holds.
        bus.dividend = 32'd5;
        bus.divisor  = 32'd0;
        bus.divOp    = 1'b1;
        tick();
        check("dz_zero", {31'b0, bus.div_zero}, 32'h1);
        check("dz_done", {31'b0, bus.div_done}, 32'h1);
        check("dz_hi",   bus.div_hi, 32'h0);
        check("dz_lo",   bus.div_lo, 32'h0);
        bus.divisor = 32'd7;
        tick();
        tick();
        check("dz_hold_zero", {31'b0, bus.div_zero}, 32'h1);
        bus.divOp = 1'b0;
        tick();
        check_clear("dz_clr");

        // Abort: divOp sampled low at edge 10, then a fresh 9/2.
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.divOp    = 1'b1;
        for (int e = 1; e <= 9; e++) tick();
        bus.divOp = 1'b0;
        tick();
        check_clear("abort");
        bus.dividend = 32'd9;
        bus.divisor  = 32'd2;
        bus.divOp    = 1'b1;
        expect_result("after_abort", 32'd4, 32'd1);
        bus.divOp = 1'b0;
        tick();

        // Async reset between edges 20 and 21, divOp held high throughout.
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.divOp    = 1'b1;
        for (int e = 1; e <= 20; e++) tick();
        #2;
        reset = 1'b1;
        #1;
        check_clear("rst_run");
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        #1;
        reset = 1'b0;
        expect_result("after_rst", 32'd14, 32'd2);

        // Async reset while holding a result must clear outputs before any edge.
        #2;
        reset = 1'b1;
        #1;
        check_clear("rst_done");
        bus.divOp = 1'b0;
        #1;
        reset = 1'b0;
        tick();
        check_clear("rst_done_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
